// File: rtl/key_pkg.sv
// Shared definitions for the key debounce block: per-channel FSM state
// encoding and a constant-function log2 used to size the hold counter.
package key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS_DB  = 3'd1,
    ST_PRESSED   = 3'd2,
    ST_LONG_HELD = 3'd3,
    ST_REL_DB    = 3'd4
  } key_state_t;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2_f(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, polarity normalisation, and the
// debounce / long-press FSM with its shared counter.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DB_CYCLES      = 1_000_000,
  parameter int LONG_CYCLES    = 50_000_000,
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int CNT_W          = clog2_f(LONG_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  // Pin level that means "not pressed"; the synchroniser resets to it.
  localparam logic REL_PIN = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic              sync1;
  logic              sync2;
  logic              pressed;
  key_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              long_flag;
  logic              long_hit;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= REL_PIN;
      sync2 <= REL_PIN;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign pressed = KEY_ACTIVE_LOW ? ~sync2 : sync2;

  // Debounce FSM; all outputs registered. long_hit marks the entry into
  // LONG_HELD and is re-registered into key_long, which places the long
  // pulse LONG_CYCLES+1 edges after key_press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      long_flag   <= 1'b0;
      long_hit    <= 1'b0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      long_hit    <= 1'b0;
      key_long    <= long_hit;
      case (state)
        ST_IDLE: begin
          if (pressed) begin
            state <= ST_PRESS_DB;
            cnt   <= '0;
          end
        end
        ST_PRESS_DB: begin
          if (!pressed) begin
            state <= ST_IDLE;
          end else if (cnt == DB_LAST) begin
            state     <= ST_PRESSED;
            cnt       <= '0;
            key_level <= 1'b1;
            key_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!pressed) begin
            state <= ST_REL_DB;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state     <= ST_LONG_HELD;
            long_flag <= 1'b1;
            long_hit  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_LONG_HELD: begin
          // Counter frozen here so it can never wrap into a second long pulse.
          if (!pressed) begin
            state <= ST_REL_DB;
            cnt   <= '0;
          end
        end
        ST_REL_DB: begin
          if (pressed) begin
            // Release bounce: resume holding; the long count starts over.
            state <= long_flag ? ST_LONG_HELD : ST_PRESSED;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_release <= 1'b1;
            long_flag   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Key conditioning front end: NUM_KEYS independent debounce channels turning
// raw push-button pins into clean levels and press/release/long pulses.
module key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int DB_CYCLES      = 1_000_000,
  parameter int LONG_CYCLES    = 50_000_000,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int CNT_W = clog2_f(LONG_CYCLES);

  // Reject parameter sets the counter scheme cannot honour.
  generate
    if (DB_CYCLES < 2 || LONG_CYCLES <= DB_CYCLES) begin : g_bad_params
      $error("key_debounce: need DB_CYCLES >= 2 and LONG_CYCLES > DB_CYCLES");
    end
  endgenerate

  genvar i;
  generate
    for (i = 0; i < NUM_KEYS; i++) begin : g_ch
      key_debounce_ch #(
        .DB_CYCLES      (DB_CYCLES),
        .LONG_CYCLES    (LONG_CYCLES),
        .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW),
        .CNT_W          (CNT_W)
      ) u_ch (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in[i]),
        .key_level   (key_level[i]),
        .key_press   (key_press[i]),
        .key_release (key_release[i]),
        .key_long    (key_long[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed timing scenarios plus randomized pin
// activity, checked every cycle against a stable-run reference model.
module tb_key_debounce;

  localparam int NK   = 4;
  localparam int DB   = 8;
  localparam int LONG = 32;

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_long;

  key_debounce #(
    .NUM_KEYS       (NK),
    .DB_CYCLES      (DB),
    .LONG_CYCLES    (LONG),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  int edge_n;

  // Reference model state: pin history (normalised, 1 = pressed), the
  // debounced level, how many consecutive samples disagree with it, and how
  // many consecutive pressed samples have elapsed since press/resume.
  bit m_h1   [NK];
  bit m_h2   [NK];
  bit m_lvl  [NK];
  int m_run  [NK];
  int m_hold [NK];
  bit m_lf   [NK];
  bit m_pend [NK];
  logic [NK-1:0] e_lvl, e_press, e_rel, e_long;

  int press_cnt [NK];
  int rel_cnt   [NK];
  int long_cnt  [NK];

  task automatic chk(input string tag, input logic [NK-1:0] got, input logic [NK-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %b, expected %b", tag, edge_n, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      m_h1[k] = 0; m_h2[k] = 0; m_lvl[k] = 0; m_run[k] = 0;
      m_hold[k] = 0; m_lf[k] = 0; m_pend[k] = 0;
    end
    e_lvl = '0; e_press = '0; e_rel = '0; e_long = '0;
  endtask

  task automatic model_step();
    bit p;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < NK; k++) begin
      p        = m_h2[k];
      m_h2[k]  = m_h1[k];
      m_h1[k]  = ~key_in[k];
      e_press[k] = 1'b0;
      e_rel[k]   = 1'b0;
      e_long[k]  = m_pend[k];
      m_pend[k]  = 0;
      if (!m_lvl[k]) begin
        if (p) begin
          m_run[k]++;
          if (m_run[k] == DB + 1) begin
            m_lvl[k] = 1; e_press[k] = 1'b1; m_run[k] = 0; m_hold[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end else begin
        if (p) begin
          if (m_run[k] > 0) begin
            m_run[k] = 0; m_hold[k] = 0;
          end else if (!m_lf[k]) begin
            m_hold[k]++;
            if (m_hold[k] == LONG) begin
              m_lf[k] = 1; m_pend[k] = 1;
            end
          end
        end else begin
          m_run[k]++;
          if (m_run[k] == DB + 1) begin
            m_lvl[k] = 0; e_rel[k] = 1'b1; m_run[k] = 0; m_lf[k] = 0;
          end
        end
      end
      e_lvl[k] = m_lvl[k];
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NK; k++) begin
      press_cnt[k] = 0; rel_cnt[k] = 0; long_cnt[k] = 0;
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    edge_n++;
    model_step();
    @(negedge clk);
    chk("level",   key_level,   e_lvl);
    chk("press",   key_press,   e_press);
    chk("release", key_release, e_rel);
    chk("long",    key_long,    e_long);
    for (int k = 0; k < NK; k++) begin
      press_cnt[k] += int'(key_press[k]);
      rel_cnt[k]   += int'(key_release[k]);
      long_cnt[k]  += int'(key_long[k]);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int seg_left [NK];
  bit seg_val  [NK];

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    edge_n = 0;
    rst_n  = 1'b0;
    key_in = '1;
    model_reset();
    clear_counts();
    #1;
    chk("rst_level", key_level, '0);
    chk("rst_pulse", key_press | key_release | key_long, '0);
    steps(3);

    // Clean press and long press on key 0, then release.
    rst_n = 1'b1;
    key_in[0] = 1'b0;
    edge_n = 0;
    steps(10);
    chk("t1_no_press_e10", key_press & 4'b0001, 4'b0000);
    step();
    chk("t1_press_e11", key_press & 4'b0001, 4'b0001);
    chk("t1_level_e11", key_level & 4'b0001, 4'b0001);
    step();
    chk("t1_press_gone_e12", key_press & 4'b0001, 4'b0000);
    steps(31);
    chk("t3_no_long_e43", key_long & 4'b0001, 4'b0000);
    step();
    chk("t3_long_e44", key_long & 4'b0001, 4'b0001);
    steps(16);
    key_in[0] = 1'b1;
    steps(10);
    chk("t3_no_rel_e70", key_release & 4'b0001, 4'b0000);
    step();
    chk("t3_rel_e71", key_release & 4'b0001, 4'b0001);
    chk("t3_level_e71", key_level & 4'b0001, 4'b0000);
    chk("t3_long_once", 4'(long_cnt[0]), 4'd1);
    steps(5);

    // Bounce rejection on key 1.
    clear_counts();
    for (int r = 0; r < 4; r++) begin
      key_in[1] = 1'b0; steps(5);
      key_in[1] = 1'b1; step();
    end
    steps(15);
    chk("t2_bounce_press", 4'(press_cnt[1]), 4'd0);
    chk("t2_bounce_level", key_level & 4'b0010, 4'b0000);

    // Release bounce while in LONG_HELD on key 0.
    clear_counts();
    key_in[0] = 1'b0; steps(50);
    key_in[0] = 1'b1; steps(3);
    key_in[0] = 1'b0; steps(20);
    chk("t4_no_rel_on_bounce", 4'(rel_cnt[0]), 4'd0);
    key_in[0] = 1'b1; steps(20);
    chk("t4_one_rel", 4'(rel_cnt[0]), 4'd1);
    chk("t4_one_long", 4'(long_cnt[0]), 4'd1);

    // Keys 2 and 3 pressed together.
    key_in[3:2] = 2'b00;
    edge_n = 0;
    steps(11);
    chk("t5_simul_press", key_press, 4'b1100);
    key_in[3:2] = 2'b11;
    steps(20);

    // Reset during PRESSED, key still held afterwards.
    clear_counts();
    key_in[0] = 1'b0;
    steps(15);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_level", key_level, '0);
    chk("t6_rst_pulse", key_press | key_release | key_long, '0);
    steps(3);
    rst_n = 1'b1;
    edge_n = 0;
    steps(11);
    chk("t6_repress_e11", key_press & 4'b0001, 4'b0001);
    steps(5);
    chk("t6_no_release", 4'(rel_cnt[0]), 4'd0);
    key_in = '1;
    steps(15);

    // Randomized pin activity on all keys.
    for (int k = 0; k < NK; k++) begin
      seg_left[k] = 0;
      seg_val[k]  = 1'b1;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (seg_left[k] == 0) begin
          seg_val[k] = ~seg_val[k];
          case ($urandom_range(0, 2))
            0:       seg_left[k] = $urandom_range(1, 6);
            1:       seg_left[k] = $urandom_range(7, 20);
            default: seg_left[k] = $urandom_range(35, 60);
          endcase
        end
        key_in[k] = seg_val[k];
        seg_left[k]--;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
